// File: rtl/intra_index_addr_gen_if.sv
// Handshake and LUT-side bus between the block controller, the index LUT bank
// and the downstream reference-sample fetch stage.
interface intra_index_addr_gen_if;
    localparam int unsigned MODE_W = 6;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned GRP_W  = 3;

    logic              start;
    logic [MODE_W-1:0] mode;
    logic [SIZE_W-1:0] blk_size;
    logic              ready;
    logic [ADDR_W-1:0] address;
    logic              angle_or_planar;
    logic              lut_valid;
    logic [ROW_W-1:0]  lut_row;
    logic [GRP_W-1:0]  lut_grp;
    logic              lut_last;
    logic              is_hor;
    logic              busy;
    logic              done;

    // Requester side: drives block requests and back-pressure
    modport master (
        output start, mode, blk_size, ready,
        input  address, angle_or_planar, lut_valid, lut_row, lut_grp,
               lut_last, is_hor, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, mode, blk_size, ready,
        output address, angle_or_planar, lut_valid, lut_row, lut_grp,
               lut_last, is_hor, busy, done
    );
endinterface

// File: rtl/intra_index_addr_gen.sv
// Walks every row and 4-sample column group of one intra prediction block,
// addressing the angle index LUT and tagging each beat in step with LUT data.
module intra_index_addr_gen #(
    parameter int unsigned LUT_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    intra_index_addr_gen_if.slave  bus
);
    localparam int unsigned MODE_W = 6;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned ANG_W  = 4;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned GRP_W  = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [MODE_W-1:0] mode_q;
    logic [SIZE_W-1:0] size_q;
    logic [ROW_W-1:0]  row_q;
    logic [GRP_W-1:0]  grp_q;
    logic              busy_q;
    logic              is_hor_q;

    logic [ANG_W-1:0]  angle_idx;
    logic              angular;
    logic [ROW_W-1:0]  row_max;
    logic [GRP_W-1:0]  grp_max;
    logic              last_beat;
    logic              issue;

    logic              valid_pipe [LUT_LATENCY];
    logic [ROW_W-1:0]  row_pipe   [LUT_LATENCY];
    logic [GRP_W-1:0]  grp_pipe   [LUT_LATENCY];
    logic              last_pipe  [LUT_LATENCY];

    // Fold the 33 angular modes onto 16 LUT angles; vertical/horizontal pure modes are non-angular
    always_comb begin
        angle_idx = '0;
        angular   = 1'b0;
        if (mode_q >= MODE_W'(2) && mode_q <= MODE_W'(9)) begin
            angle_idx = ANG_W'(mode_q - MODE_W'(2));
            angular   = 1'b1;
        end else if (mode_q >= MODE_W'(11) && mode_q <= MODE_W'(18)) begin
            angle_idx = ANG_W'(mode_q - MODE_W'(3));
            angular   = 1'b1;
        end else if ((mode_q >= MODE_W'(19) && mode_q <= MODE_W'(25)) ||
                     (mode_q >= MODE_W'(27) && mode_q <= MODE_W'(34))) begin
            angle_idx = ANG_W'(MODE_W'(34) - mode_q);
            angular   = 1'b1;
        end
    end

    // Block geometry limits and the beat-issue condition
    always_comb begin
        row_max   = ROW_W'((CNT_W'(4) << size_q) - CNT_W'(1));
        grp_max   = GRP_W'((CNT_W'(1) << size_q) - CNT_W'(1));
        last_beat = (row_q == row_max) && (grp_q == grp_max);
        issue     = (state == RUN) && bus.ready;
    end

    // Block controller: latch request, step row/group on each accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= '0;
            size_q   <= '0;
            row_q    <= '0;
            grp_q    <= '0;
            busy_q   <= 1'b0;
            is_hor_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        size_q   <= bus.blk_size;
                        is_hor_q <= (bus.mode >= MODE_W'(2)) && (bus.mode <= MODE_W'(17));
                        row_q    <= '0;
                        grp_q    <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_beat) begin
                            row_q  <= '0;
                            grp_q  <= '0;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else if (grp_q == grp_max) begin
                            grp_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            grp_q <= grp_q + GRP_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline matched to the LUT read latency; reset drops in-flight beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LUT_LATENCY); i++) begin
                valid_pipe[i] <= 1'b0;
                row_pipe[i]   <= '0;
                grp_pipe[i]   <= '0;
                last_pipe[i]  <= 1'b0;
            end
        end else begin
            valid_pipe[0] <= issue;
            row_pipe[0]   <= row_q;
            grp_pipe[0]   <= grp_q;
            last_pipe[0]  <= issue && last_beat;
            for (int i = 1; i < int'(LUT_LATENCY); i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                row_pipe[i]   <= row_pipe[i-1];
                grp_pipe[i]   <= grp_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
            end
        end
    end

    assign bus.address         = (state == RUN) ? {angle_idx, row_q} : '0;
    assign bus.angle_or_planar = issue && angular;
    assign bus.lut_valid       = valid_pipe[LUT_LATENCY-1];
    assign bus.lut_row         = row_pipe[LUT_LATENCY-1];
    assign bus.lut_grp         = grp_pipe[LUT_LATENCY-1];
    assign bus.lut_last        = last_pipe[LUT_LATENCY-1];
    assign bus.done            = valid_pipe[LUT_LATENCY-1] && last_pipe[LUT_LATENCY-1];
    assign bus.busy            = busy_q;
    assign bus.is_hor          = is_hor_q;
endmodule

// File: tb/tb_intra_index_addr_gen.sv
// Directed bench for the intra index address sequencer.
module tb_intra_index_addr_gen;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    intra_index_addr_gen_if bus ();

    intra_index_addr_gen #(.LUT_LATENCY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One whole block: hand-supplied angle/class expectations, optional stalls
    // and start held high for the whole block to show it is ignored while busy
    task automatic run_block(input string name, input logic [5:0] m, input logic [1:0] sz,
                             input logic [3:0] exp_ang, input logic exp_angular,
                             input logic exp_hor, input logic stall, input logic hold_start);
        int   n;
        int   g;
        int   total;
        int   b;
        int   cyc;
        int   er;
        int   eg;
        logic rdy;
        n     = 4 << sz;
        g     = 1 << sz;
        total = n * n / 4;
        b     = 0;
        cyc   = 0;
        check({name, ".idle_busy"}, 32'(bus.busy), 0);
        check({name, ".idle_valid"}, 32'(bus.lut_valid), 0);
        bus.start    = 1'b1;
        bus.mode     = m;
        bus.blk_size = sz;
        bus.ready    = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) bus.start = 1'b0;
        bus.mode     = 6'd26;
        bus.blk_size = ~sz;
        while (b < total && cyc < 4000) begin
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            bus.ready = rdy;
            #1;
            er = b / g;
            eg = b % g;
            check({name, ".busy"}, 32'(bus.busy), 1);
            check({name, ".addr"}, 32'(bus.address), 32'({exp_ang, 5'(er)}));
            check({name, ".rden"}, 32'(bus.angle_or_planar), 32'(rdy & exp_angular));
            check({name, ".is_hor"}, 32'(bus.is_hor), 32'(exp_hor));
            @(posedge clk); #1;
            check({name, ".valid"}, 32'(bus.lut_valid), 32'(rdy));
            if (rdy) begin
                check({name, ".row"}, 32'(bus.lut_row), 32'(er));
                check({name, ".grp"}, 32'(bus.lut_grp), 32'(eg));
                check({name, ".last"}, 32'(bus.lut_last), 32'(b == total - 1));
                check({name, ".done"}, 32'(bus.done), 32'(b == total - 1));
                b++;
            end else begin
                check({name, ".done_stall"}, 32'(bus.done), 0);
            end
            cyc++;
        end
        check({name, ".beats_in_budget"}, 32'(b), 32'(total));
        bus.start = 1'b0;
        bus.ready = 1'b1;
        check({name, ".busy_drop"}, 32'(bus.busy), 0);
        @(posedge clk); #1;
        check({name, ".post_valid"}, 32'(bus.lut_valid), 0);
        check({name, ".post_done"}, 32'(bus.done), 0);
        check({name, ".post_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.mode     = '0;
        bus.blk_size = '0;
        bus.ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.addr", 32'(bus.address), 0);
        check("rst.rden", 32'(bus.angle_or_planar), 0);
        check("rst.valid", 32'(bus.lut_valid), 0);
        check("rst.row", 32'(bus.lut_row), 0);
        check("rst.grp", 32'(bus.lut_grp), 0);
        check("rst.last", 32'(bus.lut_last), 0);
        check("rst.is_hor", 32'(bus.is_hor), 0);
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.done", 32'(bus.done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_block("m2_4x4",    6'd2,  2'd0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0);
        run_block("m30_8x8",   6'd30, 2'd1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b1);
        run_block("m11_32x32", 6'd11, 2'd3, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0);
        run_block("m26_4x4",   6'd26, 2'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        run_block("m5_stall",  6'd5,  2'd1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0);
        run_block("m22_4x4",   6'd22, 2'd0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        run_block("m40_4x4",   6'd40, 2'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a 16x16 block while a beat is being issued
        bus.start    = 1'b1;
        bus.mode     = 6'd5;
        bus.blk_size = 2'd2;
        bus.ready    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst.pre_valid", 32'(bus.lut_valid), 1);
        rst = 1'b1;
        #1;
        check("midrst.busy", 32'(bus.busy), 0);
        check("midrst.valid", 32'(bus.lut_valid), 0);
        check("midrst.addr", 32'(bus.address), 0);
        check("midrst.rden", 32'(bus.angle_or_planar), 0);
        check("midrst.is_hor", 32'(bus.is_hor), 0);
        check("midrst.row", 32'(bus.lut_row), 0);
        check("midrst.done", 32'(bus.done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.held_valid", 32'(bus.lut_valid), 0);
        @(posedge clk); #1;
        check("midrst.no_stale", 32'(bus.lut_valid), 0);

        run_block("m18_after_rst", 6'd18, 2'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
